// File: rtl/calc_pkg.sv
// Shared calculator definitions: phase encoding consumed by the display driver
// and ALU, plus the datapath width.
package calc_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    ST_SEL  = 2'b00,
    ST_IN_A = 2'b01,
    ST_IN_B = 2'b10,
    ST_RES  = 2'b11
  } phase_t;

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer, stable-sample debounce counter and rising-edge press
// detector for a raw, bouncy push-button.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 200000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic press
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             deb;
  logic             deb_d;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      deb   <= 1'b0;
      deb_d <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      deb_d <= deb;
      // Any sample agreeing with the current level restarts the stability count.
      if (sync2 == deb) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        deb <= ~deb;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign level = deb;
  assign press = deb & ~deb_d;

endmodule

// File: rtl/input_collector.sv
// Calculator input front end: debounced confirm button steps SEL -> IN_A ->
// IN_B -> RES, latching mode and operands from the switches.
// Build option: define SIGN_EXT_EN to sign-extend operands (default zero-extend).
module input_collector
  import calc_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 200000,
  parameter int unsigned SW_WIDTH        = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SW_WIDTH-1:0] sw_i,
  input  logic                confirm_i,
  output logic [3:0]          mode_o,
  output logic [1:0]          state_o,
  output logic [DATA_W-1:0]   a_o,
  output logic [DATA_W-1:0]   b_o,
  output logic                done_o
);

  phase_t            state;
  logic              press;
  logic              confirm_level_unused;
  logic [DATA_W-1:0] sw_ext;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_confirm (
    .clk  (clk),
    .rst  (rst),
    .btn  (confirm_i),
    .level(confirm_level_unused),
    .press(press)
  );

`ifdef SIGN_EXT_EN
  assign sw_ext = DATA_W'($signed(sw_i));
`else
  assign sw_ext = DATA_W'(sw_i);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_SEL;
      mode_o <= '0;
      a_o    <= '0;
      b_o    <= '0;
      done_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (press) begin
        case (state)
          ST_SEL: begin
            mode_o <= sw_i[3:0];
            state  <= ST_IN_A;
          end
          ST_IN_A: begin
            a_o   <= sw_ext;
            state <= ST_IN_B;
          end
          ST_IN_B: begin
            b_o    <= sw_ext;
            done_o <= 1'b1;
            state  <= ST_RES;
          end
          ST_RES: begin
            state <= ST_SEL;
          end
          default: begin
            state <= ST_SEL;
          end
        endcase
      end
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_input_collector.sv
// Randomized scoreboard bench for input_collector: a reference model predicts
// each phase transition (edge number and outputs); a monitor checks DUT events.
module tb_input_collector;

  localparam int unsigned DC  = 4;
  localparam int unsigned SWW = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           confirm_i = 1'b0;
  logic [SWW-1:0] sw_i = '0;
  logic [3:0]     mode_o;
  logic [1:0]     state_o;
  logic [31:0]    a_o;
  logic [31:0]    b_o;
  logic           done_o;

  always #5 clk = ~clk;

  input_collector #(
    .DEBOUNCE_CYCLES(DC),
    .SW_WIDTH(SWW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sw_i(sw_i),
    .confirm_i(confirm_i),
    .mode_o(mode_o),
    .state_o(state_o),
    .a_o(a_o),
    .b_o(b_o),
    .done_o(done_o)
  );

  typedef struct {
    int unsigned edge_n;
    logic [1:0]  st;
    logic [3:0]  mode;
    logic [31:0] a;
    logic [31:0] b;
    logic        done;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned checks = 0;
  int unsigned passes = 0;
  int unsigned events_seen = 0;
  int unsigned ecount = 0;
  bit          rst_edge = 1'b0;

  function automatic logic [31:0] ext(logic [7:0] s);
    logic [31:0] r;
    r = 32'(s);
`ifdef SIGN_EXT_EN
    if (s[7]) r = r - 32'd256;
`endif
    return r;
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s got=%h exp=%h (t=%0t)", name, got, exp, $time);
  endtask

  // Reference model: the debounced level flips once the last DC synchronized
  // samples since the previous flip all disagree with it; a press is a 0->1 flip
  // seen one edge later. Each press advances a 4-phase counter.
  bit          m_s1, m_s2, m_lv, m_lv_prev, m_press, m_cmp, m_all;
  bit          m_hist[$];
  int unsigned m_phase;
  logic [3:0]  m_mode;
  logic [31:0] m_a, m_b;

  always @(posedge clk) begin
    ecount++;
    rst_edge = rst;
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_lv = 0; m_lv_prev = 0;
      m_hist.delete();
      m_phase = 0; m_mode = '0; m_a = '0; m_b = '0;
    end else begin
      m_press = m_lv && !m_lv_prev;
      m_cmp = m_s2;
      m_s2 = m_s1;
      m_s1 = confirm_i;
      m_hist.push_back(m_cmp);
      if (m_hist.size() > DC) void'(m_hist.pop_front());
      m_lv_prev = m_lv;
      m_all = (m_hist.size() == DC);
      foreach (m_hist[i]) if (m_hist[i] == m_lv) m_all = 0;
      if (m_all) begin
        m_lv = !m_lv;
        m_hist.delete();
      end
      if (m_press) begin
        m_phase = (m_phase + 1) % 4;
        if (m_phase == 1) m_mode = sw_i[3:0];
        if (m_phase == 2) m_a = ext(sw_i);
        if (m_phase == 3) m_b = ext(sw_i);
        exp_q.push_back('{ecount, 2'(m_phase), m_mode, m_a, m_b, m_phase == 3});
      end
    end
  end

  logic [1:0] prev_state = 2'b00;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_edge) begin
      while (exp_q.size() > 0 && exp_q[0].edge_n < ecount) begin
        e = exp_q.pop_front();
        check("missed_event_edge", 32'(ecount), 32'(e.edge_n));
      end
      if (state_o !== prev_state || done_o !== 1'b0) begin
        events_seen++;
        if (exp_q.size() == 0) begin
          check("unexpected_event_state", 32'(state_o), 32'(prev_state));
        end else begin
          e = exp_q.pop_front();
          check("event_edge", 32'(ecount), 32'(e.edge_n));
          check("event_state", 32'(state_o), 32'(e.st));
          check("event_mode", 32'(mode_o), 32'(e.mode));
          check("event_a", a_o, e.a);
          check("event_b", b_o, e.b);
          check("event_done", 32'(done_o), 32'(e.done));
        end
      end
    end
    prev_state = state_o;
  end

  task automatic tick(logic c, logic [7:0] s, logic r);
    confirm_i = c;
    sw_i = s;
    rst = r;
    @(posedge clk);
    #2;
  endtask

  task automatic hold(logic c, logic [7:0] s, int unsigned n);
    repeat (n) tick(c, s, 1'b0);
  endtask

  task automatic press_btn(logic [7:0] s);
    hold(1'b1, s, DC + 4);
    hold(1'b0, s, DC + 4);
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_state"}, 32'(state_o), 32'd0);
    check({tag, "_mode"}, 32'(mode_o), 32'd0);
    check({tag, "_a"}, a_o, 32'd0);
    check({tag, "_b"}, b_o, 32'd0);
    check({tag, "_done"}, 32'(done_o), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned ev0;
    int unsigned n;
    int unsigned hi;
    int unsigned lo;
    logic [1:0]  st0;
    logic [7:0]  s;

    tick(1'b0, 8'h00, 1'b1);
    tick(1'b0, 8'h00, 1'b1);
    check_reset_outputs("reset");
    hold(1'b0, 8'h00, 2);

    // Full sequence
    press_btn(8'h05);
    check("seq_state_a", 32'(state_o), 32'd1);
    check("seq_mode", 32'(mode_o), 32'h5);
    press_btn(8'h3C);
    check("seq_a", a_o, 32'h3C);
    press_btn(8'hF0);
    check("seq_state_res", 32'(state_o), 32'd3);
    check("seq_b", b_o, ext(8'hF0));
    s = 8'($urandom);
    press_btn(s);
    check("seq_state_sel", 32'(state_o), 32'd0);
    check("seq_a_held", a_o, 32'h3C);
    check("seq_b_held", b_o, ext(8'hF0));

    // Bounce rejection
    ev0 = events_seen;
    st0 = state_o;
    n = 0;
    while (n < 40) begin
      hi = $urandom_range(1, 3);
      lo = $urandom_range(1, 3);
      hold(1'b1, 8'h11, hi);
      hold(1'b0, 8'h11, lo);
      n += hi + lo;
    end
    hold(1'b0, 8'h11, 10);
    check("bounce_events", events_seen - ev0, 32'd0);
    check("bounce_state", 32'(state_o), 32'(st0));

    // Latency and hold
    tick(1'b0, 8'h00, 1'b1);
    tick(1'b0, 8'h00, 1'b1);
    hold(1'b1, 8'hA7, 6);
    check("latency_edge6_state", 32'(state_o), 32'd0);
    hold(1'b1, 8'hA7, 1);
    check("latency_edge7_state", 32'(state_o), 32'd1);
    check("latency_mode", 32'(mode_o), 32'h7);
    hold(1'b1, 8'hA7, 93);
    check("hold_state", 32'(state_o), 32'd1);
    hold(1'b0, 8'hA7, 10);

    // Reset mid-operation, then button held through reset release
    press_btn(8'h3C);
    check("midop_state", 32'(state_o), 32'd2);
    check("midop_a", a_o, 32'h3C);
    tick(1'b1, 8'h00, 1'b1);
    check_reset_outputs("midop_reset");
    hold(1'b1, 8'h00, 6);
    check("heldrst_edge6_state", 32'(state_o), 32'd0);
    hold(1'b1, 8'h00, 1);
    check("heldrst_edge7_state", 32'(state_o), 32'd1);
    hold(1'b0, 8'h00, 10);

    // Release debounce
    ev0 = events_seen;
    hold(1'b1, 8'h42, DC + 4);
    hold(1'b0, 8'h42, 3);
    hold(1'b1, 8'h42, DC + 4);
    hold(1'b0, 8'h42, 10);
    check("short_release_presses", events_seen - ev0, 32'd1);
    hold(1'b1, 8'h42, DC + 4);
    hold(1'b0, 8'h42, 10);
    check("long_release_presses", events_seen - ev0, 32'd2);

    // Random run lengths
    repeat (150) begin
      s = 8'($urandom);
      hold(1'b1, s, $urandom_range(1, 12));
      hold(1'b0, s, $urandom_range(1, 12));
    end
    hold(1'b0, 8'h00, 20);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
